usbserial_fifo_bridge: RTL

//  Byte-stream buffer between usb_uart_core's uart_in/uart_out pipelines and the TT pin handshakes.
//  One FIFO per direction, depth and data width parametrised, fill levels exported.

---
 rtl/usbserial_pkg.sv | 23 ++
 rtl/usbserial_fifo_bridge_if.sv | 22 ++
 rtl/usbserial_sync_fifo.sv | 76 +++++++
 rtl/usbserial_fifo_bridge.sv | 117 +++++++++++
 4 files changed

// File: rtl/usbserial_pkg.sv
// usbserial_pkg
//   Shared defaults and elaboration helpers for the USB-serial FIFO bridge.
//   DATA_W_DEF / DEPTH_DEF / DBG_W_DEF : default stream width, FIFO depth, probe width
//   DEPTH_MIN                          : smallest legal FIFO depth
//   lvl_w(depth)                       : width of a fill-level counter that can hold 0..depth
//   depth_ok(depth)                    : true when depth is a power of two and >= DEPTH_MIN
package usbserial_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 4;
  localparam int DBG_W_DEF  = 12;
  localparam int DEPTH_MIN  = 2;

  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Pointers wrap by plain binary overflow, so the depth must be a power of two.
  function automatic bit depth_ok(input int depth);
    return (depth >= DEPTH_MIN) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/usbserial_fifo_bridge_if.sv
// usbserial_fifo_bridge_if
//   One valid/ready byte-stream link.
//   data  : DATA_W payload, driven by the producer
//   valid : producer has a word on data
//   ready : consumer can take a word this cycle
//   modport master : producer side (drives data/valid, sees ready)
//   modport slave  : consumer side (sees data/valid, drives ready)
//   A transfer happens on a clock edge where valid and ready are both high.
interface usbserial_fifo_bridge_if
  import usbserial_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/usbserial_sync_fifo.sv
// usbserial_sync_fifo
//   Single-clock FIFO with valid/ready on both sides and an exported fill level.
//   clk, reset : clock and synchronous active-high reset
//   push_if    : slave link, words entering the FIFO
//   pop_if     : master link, head entry leaving the FIFO
//   level      : number of stored entries, 0..DEPTH
//   Output data comes from storage only (no push-to-pop bypass), so a word
//   pushed into an empty FIFO becomes visible one cycle later.
//   Full/empty are derived from level; ready is low whenever full, even if a
//   pop happens in the same cycle.
module usbserial_sync_fifo
  import usbserial_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  usbserial_fifo_bridge_if.slave    push_if,
  usbserial_fifo_bridge_if.master   pop_if,
  output logic [lvl_w(DEPTH)-1:0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = lvl_w(DEPTH);

  generate
    if (!depth_ok(DEPTH)) begin : g_depth_check
      $error("usbserial_sync_fifo: DEPTH must be a power of two and at least 2");
    end
  endgenerate

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              full;
  logic              empty;
  logic              do_push;
  logic              do_pop;

  assign full  = (level == LVL_W'(DEPTH));
  assign empty = (level == '0);

  assign push_if.ready = !full;
  assign pop_if.valid  = !empty;
  assign pop_if.data   = mem[rd_ptr];

  assign do_push = push_if.valid && !full;
  assign do_pop  = !empty && pop_if.ready;

  // Storage is cleared on reset so the data output reads zero out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_if.data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/usbserial_fifo_bridge.sv
// usbserial_fifo_bridge
//   Byte-stream buffer between the USB UART core pipelines and the pin
//   handshakes, one FIFO per direction, plus an optional debug scan-out.
//   clk, reset          : single clock, synchronous active-high reset
//   core_out (slave)    : bytes from the USB host (core uart_out)
//   pin_out  (master)   : those bytes toward the pins
//   pin_in   (slave)    : bytes from the pins toward the USB host
//   core_in  (master)   : those bytes into the core uart_in
//   rx_level, tx_level  : fill levels of the core->pin and pin->core FIFOs
//   dbg_bus, dbg_rst    : probe inputs and scan frame restart
//   dbg_sdo, dbg_sync   : serial probe data (LSB first) and bit-0 marker
// Build option:
//   USBSERIAL_DEBUG_SCAN_EN defined   : scan serialiser present.
//   USBSERIAL_DEBUG_SCAN_EN undefined : no scan registers, dbg_sdo/dbg_sync tie
//                                       to 0, dbg_bus/dbg_rst are ignored.
// DBG_INTERNAL=1 scans the bridge's own {tx_level, rx_level, flags} word,
// zero-padded (or truncated from the top) to DBG_W, instead of dbg_bus.
module usbserial_fifo_bridge
  import usbserial_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int DEPTH        = DEPTH_DEF,
  parameter int DBG_W        = DBG_W_DEF,
  parameter bit DBG_INTERNAL = 1'b0
) (
  input  logic                      clk,
  input  logic                      reset,
  usbserial_fifo_bridge_if.slave    core_out,
  usbserial_fifo_bridge_if.master   pin_out,
  usbserial_fifo_bridge_if.slave    pin_in,
  usbserial_fifo_bridge_if.master   core_in,
  output logic [lvl_w(DEPTH)-1:0]   rx_level,
  output logic [lvl_w(DEPTH)-1:0]   tx_level,
  input  logic [DBG_W-1:0]          dbg_bus,
  input  logic                      dbg_rst,
  output logic                      dbg_sdo,
  output logic                      dbg_sync
);

  usbserial_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_if (core_out),
    .pop_if  (pin_out),
    .level   (rx_level)
  );

  usbserial_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_if (pin_in),
    .pop_if  (core_in),
    .level   (tx_level)
  );

`ifdef USBSERIAL_DEBUG_SCAN_EN
  localparam int LVL_W   = lvl_w(DEPTH);
  localparam int CNT_W   = $clog2(DBG_W);
  localparam int PROBE_W = 2 * LVL_W + 4;

  logic [DBG_W-1:0] scan_src;
  logic [DBG_W-1:0] shadow;
  logic [CNT_W-1:0] cnt;

  generate
    if (DBG_INTERNAL) begin : g_probe_int
      logic [PROBE_W-1:0] probe;
      assign probe = {tx_level, rx_level,
                      tx_level == LVL_W'(DEPTH), tx_level == '0,
                      rx_level == LVL_W'(DEPTH), rx_level == '0};
      assign scan_src = DBG_W'(probe);
      wire unused_dbg_bus = &{1'b0, dbg_bus};
    end else begin : g_probe_ext
      assign scan_src = dbg_bus;
    end
  endgenerate

  // cnt==0 captures a whole snapshot so every frame is coherent; later bits
  // come from the shadow, not the live bus. dbg_rst only re-aims the counter,
  // the serial outputs hold until the capture edge that follows.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      shadow   <= '0;
      dbg_sdo  <= 1'b0;
      dbg_sync <= 1'b0;
    end else if (dbg_rst) begin
      cnt <= '0;
    end else begin
      if (cnt == '0) begin
        shadow   <= scan_src;
        dbg_sdo  <= scan_src[0];
        dbg_sync <= 1'b1;
      end else begin
        dbg_sdo  <= shadow[cnt];
        dbg_sync <= 1'b0;
      end
      if (cnt == CNT_W'(DBG_W - 1)) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
`else
  assign dbg_sdo  = 1'b0;
  assign dbg_sync = 1'b0;
  wire unused_dbg = &{1'b0, dbg_bus, dbg_rst, DBG_INTERNAL};
`endif

endmodule
